// File: rtl/e203_itcm_arb.sv
// rtl/e203_itcm_arb.sv - two-master ICB arbiter (IFU + LSU) onto the single ITCM port
//
// Purpose: combinationally grants the ITCM command port to the LSU or the IFU,
// records the source of every accepted command in a small outstanding FIFO and
// steers each ITCM response back to the master at the FIFO head. Also tracks
// whether the SRAM output register still holds the IFU's last fetch.
//
// Optional feature: define E203_ITCM_ARB_ANTISTARVE_EN to add a saturating
// IFU starvation counter that promotes the IFU over the LSU after STARVE_MAX
// consecutive blocked cycles. Undefined: strict LSU priority.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ifu_cmd_*  / ifu_rsp_*       IFU ICB port (commands are always reads)
//   lsu_cmd_*  / lsu_rsp_*       LSU ICB port
//   itcm_cmd_* / itcm_rsp_*      shared ITCM ICB port
//   ifu_holdup                   ITCM output still holds the last IFU read data
//   arb_idle                     no outstanding transactions
module e203_itcm_arb #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 64,
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_cmd_valid,
  output logic            ifu_cmd_ready,
  input  logic [AW-1:0]   ifu_cmd_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic            ifu_rsp_err,
  output logic [DW-1:0]   ifu_rsp_rdata,
  input  logic            lsu_cmd_valid,
  output logic            lsu_cmd_ready,
  input  logic            lsu_cmd_read,
  input  logic [AW-1:0]   lsu_cmd_addr,
  input  logic [DW-1:0]   lsu_cmd_wdata,
  input  logic [DW/8-1:0] lsu_cmd_wmask,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic            lsu_rsp_err,
  output logic [DW-1:0]   lsu_rsp_rdata,
  output logic            itcm_cmd_valid,
  input  logic            itcm_cmd_ready,
  output logic            itcm_cmd_read,
  output logic [AW-1:0]   itcm_cmd_addr,
  output logic [DW-1:0]   itcm_cmd_wdata,
  output logic [DW/8-1:0] itcm_cmd_wmask,
  input  logic            itcm_rsp_valid,
  output logic            itcm_rsp_ready,
  input  logic            itcm_rsp_err,
  input  logic [DW-1:0]   itcm_rsp_rdata,
  output logic            ifu_holdup,
  output logic            arb_idle
);

  localparam int unsigned CW = $clog2(OUTS_DEPTH + 1);
  localparam int unsigned PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  logic [OUTS_DEPTH-1:0] r_fifo_id;   // 0 = IFU, 1 = LSU
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_holdup;

  logic w_full, w_empty, w_head_lsu;
  logic w_ifu_pri, w_gnt_lsu, w_gnt_ifu;
  logic w_cmd_hs, w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_cnt == CW'(OUTS_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_head_lsu = r_fifo_id[r_rptr];

  // Grant: LSU wins unless the IFU has been promoted and is requesting.
  assign w_gnt_lsu = lsu_cmd_valid & ~(w_ifu_pri & ifu_cmd_valid);
  assign w_gnt_ifu = ifu_cmd_valid & ~w_gnt_lsu;

  // No bypass: a full FIFO blocks commands even when a pop happens this cycle.
  assign itcm_cmd_valid = (w_gnt_lsu | w_gnt_ifu) & ~w_full;
  assign lsu_cmd_ready  = w_gnt_lsu & itcm_cmd_ready & ~w_full;
  assign ifu_cmd_ready  = w_gnt_ifu & itcm_cmd_ready & ~w_full;

  assign itcm_cmd_read  = w_gnt_lsu ? lsu_cmd_read  : 1'b1;
  assign itcm_cmd_addr  = w_gnt_lsu ? lsu_cmd_addr  : ifu_cmd_addr;
  assign itcm_cmd_wdata = w_gnt_lsu ? lsu_cmd_wdata : '0;
  assign itcm_cmd_wmask = w_gnt_lsu ? lsu_cmd_wmask : '0;

  assign w_cmd_hs = itcm_cmd_valid & itcm_cmd_ready;
  assign w_push   = w_cmd_hs;

  // Responses with nothing outstanding are swallowed (ready=1, no routing).
  assign ifu_rsp_valid  = itcm_rsp_valid & ~w_empty & ~w_head_lsu;
  assign lsu_rsp_valid  = itcm_rsp_valid & ~w_empty &  w_head_lsu;
  assign itcm_rsp_ready = w_empty ? 1'b1 : (w_head_lsu ? lsu_rsp_ready : ifu_rsp_ready);
  assign w_pop          = itcm_rsp_valid & itcm_rsp_ready & ~w_empty;

  assign ifu_rsp_rdata = itcm_rsp_rdata;
  assign lsu_rsp_rdata = itcm_rsp_rdata;
  assign ifu_rsp_err   = itcm_rsp_err;
  assign lsu_rsp_err   = itcm_rsp_err;

  assign ifu_holdup = r_holdup;
  assign arb_idle   = w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_id[r_wptr] <= w_gnt_lsu;
        r_wptr            <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Any LSU access overwrites the SRAM output register, so only the most
  // recent accepted command decides whether the IFU data is still there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_holdup <= 1'b0;
    end else if (w_cmd_hs) begin
      r_holdup <= ~w_gnt_lsu;
    end
  end

`ifdef E203_ITCM_ARB_ANTISTARVE_EN
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [SW-1:0] r_starve_cnt;
  logic          r_ifu_prio;
  logic          w_starve_max;
  logic          w_ifu_hs;

  assign w_starve_max = (r_starve_cnt == SW'(STARVE_MAX));
  assign w_ifu_hs     = ifu_cmd_valid & ifu_cmd_ready;
  // The compare term lets the IFU win in the very cycle the count saturates.
  assign w_ifu_pri    = r_ifu_prio | w_starve_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_ifu_prio   <= 1'b0;
    end else if (w_ifu_hs) begin
      r_starve_cnt <= '0;
      r_ifu_prio   <= 1'b0;
    end else begin
      if (ifu_cmd_valid && !w_starve_max) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (w_starve_max) begin
        r_ifu_prio <= 1'b1;
      end
    end
  end
`else
  assign w_ifu_pri = 1'b0;
`endif

endmodule

// File: doc/e203_itcm_arb.md
# e203_itcm_arb

Two-master ICB arbiter sharing the single ITCM port between the IFU fetch path and the LSU. It sits between the IFU's ITCM ICB master port and the LSU's ITCM ICB port on one side, and the ITCM SRAM controller on the other. It arbitrates commands and tracks outstanding transactions so responses return to their originator in order. It also maintains the IFU holdup indication, which tells the IFU that the SRAM output still holds its last fetch.

## Interface
- AW, 16: ITCM address width (matches `E203_ITCM_ADDR_WIDTH`).
- DW, 64: ITCM data width.
- OUTS_DEPTH, 2: maximum outstanding transactions; power of two, ≥1.
- STARVE_MAX, 4: consecutive IFU-blocked cycles before the IFU is promoted (used only when the anti-starvation macro is defined).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ifu_cmd_valid / ifu_cmd_ready  in / out  1  IFU command handshake.
- ifu_cmd_addr  in  AW  IFU fetch address; always a read.
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake.
- ifu_rsp_err  out  1  IFU response error.
- ifu_rsp_rdata  out  DW  IFU read data.
- lsu_cmd_valid / lsu_cmd_ready  in / out  1  LSU command handshake.
- lsu_cmd_read  in  1  LSU read (1) or write (0).
- lsu_cmd_addr  in  AW  LSU address.
- lsu_cmd_wdata  in  DW  LSU write data.
- lsu_cmd_wmask  in  DW/8  LSU byte mask.
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake.
- lsu_rsp_err  out  1  LSU response error.
- lsu_rsp_rdata  out  DW  LSU read data.
- itcm_cmd_valid / itcm_cmd_ready  out / in  1  ITCM command handshake.
- itcm_cmd_read, itcm_cmd_addr, itcm_cmd_wdata, itcm_cmd_wmask  out  1/AW/DW/DW/8  muxed command fields.
- itcm_rsp_valid / itcm_rsp_ready  in / out  1  ITCM response handshake.
- itcm_rsp_err  in  1  ITCM response error.
- itcm_rsp_rdata  in  DW  ITCM read data.
- ifu_holdup  out  1  ITCM output register still holds data from the last IFU read.
- arb_idle  out  1  no outstanding transactions.

## Operation
- Grant is combinational each cycle; there is no lock while a command is pending. Masters hold valid and fields stable until their own ready, per ICB.
- Default priority: LSU over IFU. Grant is LSU if lsu_cmd_valid, otherwise IFU if ifu_cmd_valid.
- An IFU command drives itcm_cmd_read=1, wdata=0 and wmask=0.
- itcm_cmd_valid = (granted master's valid) & ~fifo_full.
- Granted master's cmd_ready = itcm_cmd_ready & ~fifo_full. The non-granted master's ready is 0.
- Outstanding FIFO: OUTS_DEPTH entries of 1-bit source ID (0=IFU, 1=LSU).
  - Push on the ITCM cmd handshake; pop on the ITCM rsp handshake.
  - When full, commands are blocked even if a pop occurs in the same cycle (no bypass).
  - Simultaneous push and pop when not full leaves the count unchanged.
- Response routing: the FIFO head ID selects the destination.
  - Destination rsp_valid = itcm_rsp_valid; rsp_ready is taken from the destination master; the other master's rsp_valid is 0.
  - rdata/err are broadcast to both masters but are only valid where rsp_valid=1.
- itcm_rsp_valid while the FIFO is empty is a protocol error. The response is dropped, itcm_rsp_ready=1, and there is no state change.
- ifu_holdup:
  - Set on an IFU cmd handshake; cleared on an LSU cmd handshake. No other events change it.
  - Any ITCM access by the LSU invalidates the IFU's held SRAM output.
- arb_idle = FIFO empty.

## Timing
- Command path is zero-latency combinational from master to ITCM. Response path is zero-latency combinational from ITCM to master.
- The FIFO count, IFU-priority flag, starvation counter and ifu_holdup update on the clk edge following the handshake.
- Reset values: FIFO empty, arb_idle=1, ifu_holdup=0, starvation counter=0, priority flag=0.
- All valid/ready outputs are combinational and follow inputs after reset deasserts.
- Reset asserted mid-transaction discards the outstanding IDs. Responses arriving afterwards fall under the empty-FIFO rule.
- Back-to-back: one command per cycle when itcm_cmd_ready=1 and the FIFO is not full. Sustained throughput is OUTS_DEPTH commands per response round trip.

## Configuration
- Macro `E203_ITCM_ARB_ANTISTARVE_EN`.
- Defined: the starvation counter (width clog2(STARVE_MAX+1), saturating) behaves as follows:
  - Increments each cycle ifu_cmd_valid=1 without an IFU handshake.
  - When the counter equals STARVE_MAX, the priority flag is set and the IFU wins over the LSU.
  - The counter and flag clear on an IFU cmd handshake.
- Undefined: strict LSU priority; the counter and flag are not instantiated.

## Test plan
- Reset, then idle: arb_idle=1, ifu_holdup=0, all valids 0.
- IFU read to 0x0040 with ITCM 1-cycle response rdata=0x1122334455667788:
  - ifu_rsp_rdata matches.
  - ifu_holdup=1 the next cycle.
  - lsu_rsp_valid stays 0.
- Simultaneous IFU and LSU valid (LSU write 0x0100, wmask=0xFF):
  - LSU granted first and ifu_holdup clears.
  - IFU granted the next cycle.
  - Responses route in order LSU then IFU.
- itcm_rsp_valid held 0 with OUTS_DEPTH=2:
  - After two accepted commands, both cmd_ready=0 even with itcm_cmd_ready=1.
  - On the first response handshake, the pop cycle still blocks commands; a command is accepted the following cycle.
- With `E203_ITCM_ARB_ANTISTARVE_EN` and STARVE_MAX=4:
  - LSU valid continuously with IFU valid: the IFU is granted on the 5th cycle, then the LSU resumes.
  - Without the macro, the IFU is never granted.
- Reset asserted with one outstanding LSU read:
  - FIFO clears and arb_idle=1.
  - A subsequent stray itcm_rsp_valid is accepted with no master rsp_valid asserted.
